// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the program counter and a hardware return-address
// stack, selecting the next PC from decoded ret/call/jump/branch flags.
module pc_sequencer #(
  parameter int                ADDR_W    = 19,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic                             branch,
  input  logic                             branch_ne,
  input  logic                             jump,
  input  logic                             call,
  input  logic                             ret,
  input  logic                             zero,
  input  logic [ADDR_W-1:0]                target,
  output logic [ADDR_W-1:0]                pc,
  output logic [ADDR_W-1:0]                pc_plus1,
  output logic                             redirect,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_full,
  output logic                             ras_empty,
  output logic                             ras_ovf,
  output logic                             ras_unf
);

  localparam int               CNT_W    = $clog2(RAS_DEPTH + 1);
  localparam int               IDX_W    = $clog2(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] slot_of(input logic [CNT_W-1:0] c);
    return IDX_W'(c);
  endfunction

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

  logic [ADDR_W-1:0] pc_nxt;
  logic              redirect_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic              push_en;
  logic              ovf_set;
  logic              unf_set;
  logic [ADDR_W-1:0] ras_top;
  logic              br_taken;

  assign pc_plus1  = pc_inc(pc);
  assign ras_full  = (ras_count == CNT_FULL);
  assign ras_empty = (ras_count == '0);
  assign ras_top   = ras_mem[slot_of(ras_count - CNT_ONE)];
  assign br_taken  = branch && (zero ^ branch_ne);

  // Fixed-priority next-PC selection; ret dominates so an illegal call+ret never pushes.
  always_comb begin
    pc_nxt       = pc_plus1;
    redirect_nxt = 1'b0;
    count_nxt    = ras_count;
    push_en      = 1'b0;
    ovf_set      = 1'b0;
    unf_set      = 1'b0;
    if (ret) begin
      if (!ras_empty) begin
        pc_nxt       = ras_top;
        count_nxt    = ras_count - CNT_ONE;
        redirect_nxt = 1'b1;
      end else begin
        unf_set = 1'b1;
      end
    end else if (call) begin
      pc_nxt       = target;
      redirect_nxt = 1'b1;
      if (!ras_full) begin
        push_en   = 1'b1;
        count_nxt = ras_count + CNT_ONE;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (jump || br_taken) begin
      pc_nxt       = target;
      redirect_nxt = 1'b1;
    end
  end

  // State update: reset beats stall, stall freezes everything but drops redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      redirect  <= 1'b0;
      ras_count <= '0;
      ras_ovf   <= 1'b0;
      ras_unf   <= 1'b0;
    end else if (stall) begin
      redirect  <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      redirect  <= redirect_nxt;
      ras_count <= count_nxt;
      ras_ovf   <= ras_ovf | ovf_set;
      ras_unf   <= ras_unf | unf_set;
    end
  end

  // Return-address storage carries no reset; only ras_count defines validity.
  always_ff @(posedge clk) begin
    if (!rst && !stall && push_en) begin
      ras_mem[slot_of(ras_count)] <= pc_plus1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic, all
// checked against a queue-based return-stack model of the next-PC rules.
module tb_pc_sequencer;

  localparam int AW    = 19;
  localparam int DEPTH = 8;
  localparam int MASK  = 'h7FFFF;

  logic          clk = 1'b0;
  logic          rst, stall, branch, branch_ne, jump, call, ret, zero;
  logic [AW-1:0] target;
  logic [AW-1:0] pc, pc_plus1;
  logic          redirect;
  logic [3:0]    ras_count;
  logic          ras_full, ras_empty, ras_ovf, ras_unf;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .branch_ne(branch_ne),
    .jump(jump), .call(call), .ret(ret), .zero(zero), .target(target),
    .pc(pc), .pc_plus1(pc_plus1), .redirect(redirect), .ras_count(ras_count),
    .ras_full(ras_full), .ras_empty(ras_empty), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int m_pc;
  int m_q[$];
  bit m_redir, m_ovf, m_unf, m_valid;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, s, br, bne, j, c, rt, z, input int t);
    if (r) begin
      m_pc = 0; m_q.delete(); m_redir = 0; m_ovf = 0; m_unf = 0; m_valid = 1;
    end else if (s) begin
      m_redir = 0;
    end else if (rt) begin
      if (m_q.size() > 0) begin
        m_pc = m_q.pop_back(); m_redir = 1;
      end else begin
        m_pc = (m_pc + 1) & MASK; m_unf = 1; m_redir = 0;
      end
    end else if (c) begin
      if (m_q.size() < DEPTH) m_q.push_back((m_pc + 1) & MASK);
      else m_ovf = 1;
      m_pc = t & MASK; m_redir = 1;
    end else if (j || (br && (z != bne))) begin
      m_pc = t & MASK; m_redir = 1;
    end else begin
      m_pc = (m_pc + 1) & MASK; m_redir = 0;
    end
  endtask

  task automatic cyc(input bit r, s, br, bne, j, c, rt, z, input int t);
    rst = r; stall = s; branch = br; branch_ne = bne; jump = j;
    call = c; ret = rt; zero = z; target = AW'(t);
    if (m_valid) check_eq("pc_plus1", 32'(pc_plus1), (m_pc + 1) & MASK);
    @(posedge clk);
    model_step(r, s, br, bne, j, c, rt, z, t);
    #1;
    check_eq("pc", 32'(pc), m_pc);
    check_eq("redirect", 32'(redirect), 32'(m_redir));
    check_eq("ras_count", 32'(ras_count), m_q.size());
    check_eq("ras_full", 32'(ras_full), 32'(m_q.size() == DEPTH));
    check_eq("ras_empty", 32'(ras_empty), 32'(m_q.size() == 0));
    check_eq("ras_ovf", 32'(ras_ovf), 32'(m_ovf));
    check_eq("ras_unf", 32'(ras_unf), 32'(m_unf));
  endtask

  task automatic do_rst();              cyc(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic idle();                cyc(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic jmp(input int t);      cyc(0, 0, 0, 0, 1, 0, 0, 0, t); endtask
  task automatic do_call(input int t);  cyc(0, 0, 0, 0, 1, 1, 0, 0, t); endtask
  task automatic do_ret();              cyc(0, 0, 0, 0, 1, 0, 1, 0, 0); endtask
  task automatic do_br(input bit bne, input bit z, input int t);
    cyc(0, 0, 1, bne, 0, 0, 0, z, t);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ret_addr[DEPTH];
    m_valid = 0;
    rst = 0; stall = 0; branch = 0; branch_ne = 0; jump = 0;
    call = 0; ret = 0; zero = 0; target = '0;

    // Reset and sequential fetch
    do_rst();
    check_eq("rst_pc", 32'(pc), 0);
    check_eq("rst_empty", 32'(ras_empty), 1);
    for (int i = 1; i <= 4; i++) begin
      idle();
      check_eq("idle_pc", 32'(pc), i);
      check_eq("idle_redirect", 32'(redirect), 0);
    end
    idle();
    check_eq("pc5", 32'(pc), 5);

    // Conditional branches
    do_br(0, 1, 'h40);
    check_eq("beq_taken_pc", 32'(pc), 'h40);
    check_eq("beq_taken_redir", 32'(redirect), 1);
    jmp(5);
    do_br(0, 0, 'h40);
    check_eq("beq_not_pc", 32'(pc), 6);
    check_eq("beq_not_redir", 32'(redirect), 0);
    jmp(5);
    do_br(1, 0, 'h40);
    check_eq("bne_taken_pc", 32'(pc), 'h40);
    do_br(1, 1, 'h80);
    check_eq("bne_not_pc", 32'(pc), 'h41);

    // Jump to pc+1 still counts as redirect
    jmp('h42);
    check_eq("jmp_seq_redir", 32'(redirect), 1);

    // Nested call/return
    jmp('h10);
    do_call('h100);
    check_eq("call1_pc", 32'(pc), 'h100);
    check_eq("call1_cnt", 32'(ras_count), 1);
    do_call('h200);
    check_eq("call2_pc", 32'(pc), 'h200);
    check_eq("call2_cnt", 32'(ras_count), 2);
    do_ret();
    check_eq("ret1_pc", 32'(pc), 'h101);
    check_eq("ret1_cnt", 32'(ras_count), 1);
    do_ret();
    check_eq("ret2_pc", 32'(pc), 'h11);
    check_eq("ret2_cnt", 32'(ras_count), 0);

    // Overflow and LIFO drain
    jmp('h500);
    for (int i = 0; i < DEPTH; i++) begin
      ret_addr[i] = (m_pc + 1) & MASK;
      do_call('h1000 + i * 'h20);
    end
    check_eq("fill_full", 32'(ras_full), 1);
    check_eq("fill_ovf", 32'(ras_ovf), 0);
    do_call('h300);
    check_eq("ovf_pc", 32'(pc), 'h300);
    check_eq("ovf_cnt", 32'(ras_count), DEPTH);
    check_eq("ovf_flag", 32'(ras_ovf), 1);
    check_eq("ovf_redir", 32'(redirect), 1);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      do_ret();
      check_eq("drain_pc", 32'(pc), ret_addr[i]);
    end
    check_eq("drain_empty", 32'(ras_empty), 1);
    check_eq("ovf_sticky", 32'(ras_ovf), 1);

    // Underflow
    jmp('h20);
    do_ret();
    check_eq("unf_pc", 32'(pc), 'h21);
    check_eq("unf_flag", 32'(ras_unf), 1);
    check_eq("unf_redir", 32'(redirect), 0);
    idle(); idle();
    check_eq("unf_sticky", 32'(ras_unf), 1);

    // Stall, reset under stall, wrap
    jmp('h30);
    do_call('h700);
    cyc(0, 1, 0, 0, 1, 1, 0, 0, 'h900);
    check_eq("stall_pc", 32'(pc), 'h700);
    check_eq("stall_cnt", 32'(ras_count), 1);
    check_eq("stall_redir", 32'(redirect), 0);
    jmp('h55);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    check_eq("rststall_pc", 32'(pc), 0);
    check_eq("rststall_ovf", 32'(ras_ovf), 0);
    check_eq("rststall_unf", 32'(ras_unf), 0);
    check_eq("rststall_cnt", 32'(ras_count), 0);
    jmp('h7FFFF);
    check_eq("wrap_pp1", 32'(pc_plus1), 0);
    idle();
    check_eq("wrap_pc", 32'(pc), 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int k;
      bit r, s, br, bne, j, c, rt, z;
      int t;
      k   = $urandom_range(0, 99);
      r   = ($urandom_range(0, 299) == 0);
      s   = ($urandom_range(0, 9) == 0);
      bne = $urandom_range(0, 1);
      z   = $urandom_range(0, 1);
      t   = $urandom_range(0, MASK);
      br = 0; j = 0; c = 0; rt = 0;
      if (k < 3) begin c = 1; rt = 1; j = 1; end
      else if (k < 30) begin c = 1; j = 1; end
      else if (k < 55) begin rt = 1; j = 1; end
      else if (k < 63) j = 1;
      else if (k < 83) br = 1;
      if (r || n == 0) cyc(1, s, br, bne, j, c, rt, z, t);
      else cyc(0, s, br, bne, j, c, rt, z, t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
